matrix_stream_frontend: RTL



---
 rtl/matrix_stream_frontend.sv | 126 ++++++++++++
 1 files changed

// File: rtl/matrix_stream_frontend.sv
// rtl/matrix_stream_frontend.sv - serial word front-end packing operands for and unpacking results from matrix_multiplier
module matrix_stream_frontend #(
    parameter int NUM_FIRST_ROW  = 2,
    parameter int NUM_FIRST_COL  = 2,
    parameter int NUM_SECOND_COL = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [31:0]                                   in_data,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic [31:0]                                   out_data,
    output logic                                          out_valid,
    input  logic                                          out_rdy,
    output logic [32*NUM_FIRST_ROW*NUM_FIRST_COL-1:0]     m_In1,
    output logic [32*NUM_FIRST_COL*NUM_SECOND_COL-1:0]    m_In2,
    output logic                                          m_load,
    input  logic [32*NUM_FIRST_ROW*NUM_SECOND_COL-1:0]    m_Out,
    input  logic                                          m_out_ready,
    output logic                                          m_out_ack
);

    localparam int NA = NUM_FIRST_ROW * NUM_FIRST_COL;
    localparam int NB = NUM_FIRST_COL * NUM_SECOND_COL;
    localparam int NR = NUM_FIRST_ROW * NUM_SECOND_COL;
    localparam int CW = $clog2(NA + NB + 1);
    localparam int RW = $clog2(NR + 1);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        LOAD     = 2'd1,
        WAIT_RES = 2'd2,
        SEND     = 2'd3
    } state_t;

    state_t              state;
    logic [CW-1:0]       word_cnt;
    logic [RW-1:0]       res_idx;
    logic                blank;
    logic [32*NR-1:0]    result;

    // Control FSM: collect operand words, pulse load, wait for the result, stream it out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= COLLECT;
            word_cnt  <= '0;
            res_idx   <= '0;
            blank     <= 1'b0;
            result    <= '0;
            m_In1     <= '0;
            m_In2     <= '0;
            m_load    <= 1'b0;
            m_out_ack <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        // First word of each matrix lands at the MSBs; B arrives column-major.
                        for (int k = 0; k < NA; k++) begin
                            if (word_cnt == CW'(k)) begin
                                m_In1[32*(NA-1-k) +: 32] <= in_data;
                            end
                        end
                        for (int k = 0; k < NB; k++) begin
                            if (word_cnt == CW'(NA + k)) begin
                                m_In2[32*(NB-1-k) +: 32] <= in_data;
                            end
                        end
                        if (word_cnt == CW'(NA + NB - 1)) begin
                            word_cnt <= '0;
                            in_ready <= 1'b0;
                            m_load   <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                LOAD: begin
                    m_load <= 1'b0;
                    blank  <= 1'b1;
                    state  <= WAIT_RES;
                end
                WAIT_RES: begin
                    // A ready left over from the previous result is masked for one cycle.
                    if (blank) begin
                        blank <= 1'b0;
                    end else if (m_out_ready) begin
                        result    <= m_Out;
                        m_out_ack <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= m_Out[32*NR-1 -: 32];
                        res_idx   <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    m_out_ack <= 1'b0;
                    if (out_valid && out_rdy) begin
                        if (res_idx == RW'(NR - 1)) begin
                            out_valid <= 1'b0;
                            res_idx   <= '0;
                            in_ready  <= 1'b1;
                            state     <= COLLECT;
                        end else begin
                            res_idx <= res_idx + 1'b1;
                            for (int k = 1; k < NR; k++) begin
                                if (res_idx == RW'(k - 1)) begin
                                    out_data <= result[32*(NR-1-k) +: 32];
                                end
                            end
                        end
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule
